// File: rtl/dispatch_credit_ctrl_pkg.sv
// Shared constants, FSM encodings and popcount helper for the dispatch credit controller.
package dispatch_credit_ctrl_pkg;

    localparam int unsigned DISPATCH_WIDTH = 4;
    localparam int unsigned IQ_SIZE        = 32;
    localparam int unsigned AL_SIZE        = 128;
    localparam int unsigned LQ_SIZE        = 32;
    localparam int unsigned SQ_SIZE        = 32;
    localparam int unsigned RECOVER_CYCLES = 3;

    localparam int unsigned IQ_CW  = $clog2(IQ_SIZE) + 1;
    localparam int unsigned AL_CW  = $clog2(AL_SIZE) + 1;
    localparam int unsigned LQ_CW  = $clog2(LQ_SIZE) + 1;
    localparam int unsigned SQ_CW  = $clog2(SQ_SIZE) + 1;
    localparam int unsigned DEM_W  = $clog2(DISPATCH_WIDTH) + 1;
    localparam int unsigned FREE_W = 3;
    localparam int unsigned RCNT_W = $clog2(RECOVER_CYCLES);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_RECOVER = 1'b1;

    function automatic logic [DEM_W-1:0] popcount(input logic [DISPATCH_WIDTH-1:0] v);
        logic [DEM_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(DISPATCH_WIDTH); i++) begin
            n = n + DEM_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/dispatch_credit_ctrl_if.sv
// Dispatch-side bundle, credit-return and status signals of the credit controller.
interface dispatch_credit_ctrl_if;
    import dispatch_credit_ctrl_pkg::*;

    logic                      flush_i;
    logic                      renameReady_i;
    logic [DISPATCH_WIDTH-1:0] instValid_i;
    logic [DISPATCH_WIDTH-1:0] isLoad_i;
    logic [DISPATCH_WIDTH-1:0] isStore_i;
    logic [FREE_W-1:0]         iqFreed_i;
    logic [FREE_W-1:0]         alFreed_i;
    logic [FREE_W-1:0]         lqFreed_i;
    logic [FREE_W-1:0]         sqFreed_i;
    logic                      stall_o;
    logic                      dispatch_o;
    logic [IQ_CW-1:0]          iqCredits_o;
    logic [AL_CW-1:0]          alCredits_o;
    logic [LQ_CW-1:0]          lqCredits_o;
    logic [SQ_CW-1:0]          sqCredits_o;
    logic                      recovering_o;

    modport slave (
        input  flush_i, renameReady_i, instValid_i, isLoad_i, isStore_i,
               iqFreed_i, alFreed_i, lqFreed_i, sqFreed_i,
        output stall_o, dispatch_o, iqCredits_o, alCredits_o, lqCredits_o,
               sqCredits_o, recovering_o
    );

    modport master (
        output flush_i, renameReady_i, instValid_i, isLoad_i, isStore_i,
               iqFreed_i, alFreed_i, lqFreed_i, sqFreed_i,
        input  stall_o, dispatch_o, iqCredits_o, alCredits_o, lqCredits_o,
               sqCredits_o, recovering_o
    );

endinterface

// File: rtl/dispatch_credit_ctrl_credit_counter.sv
// Saturating free-entry counter for one back-end resource with a sticky range-error flag.
module credit_counter
    import dispatch_credit_ctrl_pkg::*;
#(
    parameter int unsigned SIZE = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reload_i,
    input  logic [DEM_W-1:0]       consume_i,
    input  logic [FREE_W-1:0]      release_i,
    output logic [$clog2(SIZE):0]  count_o,
    output logic                   err_o
);

    localparam int unsigned CW = $clog2(SIZE) + 1;

    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic [CW:0]   sum_c, diff_c;

    // One extra bit of headroom so over/underflow is detected instead of wrapping.
    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        sum_c   = (CW+1)'(count_q) + (CW+1)'(release_i);
        diff_c  = sum_c - (CW+1)'(consume_i);
        if (reload_i) begin
            count_d = CW'(SIZE);
        end else if (sum_c < (CW+1)'(consume_i)) begin
            count_d = '0;
            err_d   = 1'b1;
        end else if (diff_c > (CW+1)'(SIZE)) begin
            count_d = CW'(SIZE);
            err_d   = 1'b1;
        end else begin
            count_d = diff_c[CW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= CW'(SIZE);
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count_o = count_q;
    assign err_o   = err_q;

endmodule

// File: rtl/dispatch_credit_ctrl.sv
// Whole-bundle dispatch gate: tracks IQ/AL/LQ/SQ credits and sequences flush recovery.
module dispatch_credit_ctrl
    import dispatch_credit_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    dispatch_credit_ctrl_if.slave bus
);

    logic [0:0]        state_q, state_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              dispatch_c, stall_c, fits_c, accept_free_c;
    logic [DEM_W-1:0]  n_inst_c, n_ld_c, n_st_c;
    logic [DEM_W-1:0]  cons_inst_c, cons_ld_c, cons_st_c;
    logic [IQ_CW-1:0]  iq_cnt;
    logic [AL_CW-1:0]  al_cnt;
    logic [LQ_CW-1:0]  lq_cnt;
    logic [SQ_CW-1:0]  sq_cnt;
    logic [3:0]        err_w;

    assign n_inst_c = popcount(bus.instValid_i);
    assign n_ld_c   = popcount(bus.instValid_i & bus.isLoad_i);
    assign n_st_c   = popcount(bus.instValid_i & bus.isStore_i);

    // Registered credits only: returns become usable one cycle later.
    assign fits_c = (iq_cnt >= IQ_CW'(n_inst_c)) && (al_cnt >= AL_CW'(n_inst_c)) &&
                    (lq_cnt >= LQ_CW'(n_ld_c))   && (sq_cnt >= SQ_CW'(n_st_c));

    always_comb begin
        state_d    = state_q;
        rcnt_d     = rcnt_q;
        dispatch_c = 1'b0;
        stall_c    = 1'b0;
        case (state_q)
            ST_RUN: begin
                dispatch_c = bus.renameReady_i && fits_c && !bus.flush_i;
                stall_c    = bus.renameReady_i && !fits_c;
                if (bus.flush_i) begin
                    state_d = ST_RECOVER;
                    rcnt_d  = RCNT_W'(RECOVER_CYCLES - 1);
                end
            end
            ST_RECOVER: begin
                stall_c = 1'b1;
                if (bus.flush_i) begin
                    rcnt_d = RCNT_W'(RECOVER_CYCLES - 1);
                end else if (rcnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    rcnt_d = rcnt_q - RCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                rcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // The back end is squashed on flush, so returns are meaningless until RUN resumes.
    assign accept_free_c = (state_q == ST_RUN) && !bus.flush_i;
    assign cons_inst_c   = dispatch_c ? n_inst_c : '0;
    assign cons_ld_c     = dispatch_c ? n_ld_c   : '0;
    assign cons_st_c     = dispatch_c ? n_st_c   : '0;

    credit_counter #(.SIZE(IQ_SIZE)) u_iq (
        .clk(clk), .reset(reset), .reload_i(bus.flush_i), .consume_i(cons_inst_c),
        .release_i(accept_free_c ? bus.iqFreed_i : '0), .count_o(iq_cnt), .err_o(err_w[0])
    );
    credit_counter #(.SIZE(AL_SIZE)) u_al (
        .clk(clk), .reset(reset), .reload_i(bus.flush_i), .consume_i(cons_inst_c),
        .release_i(accept_free_c ? bus.alFreed_i : '0), .count_o(al_cnt), .err_o(err_w[1])
    );
    credit_counter #(.SIZE(LQ_SIZE)) u_lq (
        .clk(clk), .reset(reset), .reload_i(bus.flush_i), .consume_i(cons_ld_c),
        .release_i(accept_free_c ? bus.lqFreed_i : '0), .count_o(lq_cnt), .err_o(err_w[2])
    );
    credit_counter #(.SIZE(SQ_SIZE)) u_sq (
        .clk(clk), .reset(reset), .reload_i(bus.flush_i), .consume_i(cons_st_c),
        .release_i(accept_free_c ? bus.sqFreed_i : '0), .count_o(sq_cnt), .err_o(err_w[3])
    );

    assign bus.dispatch_o   = dispatch_c;
    assign bus.stall_o      = stall_c;
    assign bus.iqCredits_o  = iq_cnt;
    assign bus.alCredits_o  = al_cnt;
    assign bus.lqCredits_o  = lq_cnt;
    assign bus.sqCredits_o  = sq_cnt;
    assign bus.recovering_o = (state_q == ST_RECOVER);

    credit_range_ok: assert property (@(posedge clk) disable iff (reset) !(|err_w));

endmodule
